// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache (port 0) and D-cache (port 1).
// Latency: accept -> mem_valid next cycle; rsp_valid the cycle after mem_rvalid or timeout.
// Backpressure: one transaction in flight; req_ready stays low until the response has been returned.
module cache_mem_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 20,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*WORD_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic                    rsp_error,
    output logic [WORD_WIDTH-1:0]   rsp_data,
    output logic [ADDR_WIDTH-1:0]   rsp_addr,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WORD_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [WORD_WIDTH-1:0]   mem_rdata
);
    localparam int          CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [31:0] TIMEOUT_U = TIMEOUT;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic          last_grant;
    logic          grant;
    logic          owner;
    logic [CW-1:0] cnt;
    logic          timed_out;
    logic          take;

    // Prefer the port that did not win last time; fall back to whichever is valid.
    assign grant     = req_valid[~last_grant] ? ~last_grant : last_grant;
    assign take      = (state == IDLE) && (|req_valid);
    assign timed_out = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) == TIMEOUT_U);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        mem_valid = 1'b0;
        rsp_valid = 2'b00;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    // Gated so the accept strobe cannot leak while reset is held.
                    req_ready[grant] = rst_n;
                    state_nxt        = ISSUE;
                end
            end
            ISSUE: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid || timed_out) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cnt        <= '0;
            rsp_error  <= 1'b0;
            rsp_data   <= '0;
            rsp_addr   <= '0;
        end else begin
            if (take) begin
                last_grant <= grant;
                owner      <= grant;
                mem_write  <= req_write[grant];
                mem_addr   <= grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                mem_wdata  <= grant ? req_wdata[2*WORD_WIDTH-1:WORD_WIDTH] : req_wdata[WORD_WIDTH-1:0];
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CW'(1);
            end
            // A completion in the same cycle as the timeout still counts as a success.
            if ((state == WAIT) && (mem_rvalid || timed_out)) begin
                rsp_error <= ~mem_rvalid;
                rsp_data  <= (mem_rvalid && !mem_write) ? mem_rdata : '0;
                rsp_addr  <= mem_addr;
            end
        end
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one memory port between two cache miss/write-back requesters: port 0 = instruction cache, port 1 = data cache.
- Round-robin arbitration with one outstanding transaction.
- Returns each completed access to its owner as a cache response: done strobe, read data, echoed physical address.
- Sits between the cache controllers and the memory model/bus.

Parameters:
- WORD_WIDTH, 32, data width (matches `WORD_WIDTH).
- ADDR_WIDTH, 20, physical address width (matches `PHYSICAL_ADDR_WIDTH).
- TIMEOUT, 255, max cycles in WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept strobe (one-hot or zero).
- req_write  in  2  1 = write, 0 = read.
- req_addr  in  2*ADDR_WIDTH  request address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*WORD_WIDTH  write data, same packing.
- rsp_valid  out  2  one-cycle completion strobe per requester.
- rsp_error  out  1  qualifies rsp_valid: 1 = timed out.
- rsp_data  out  WORD_WIDTH  read data (0 for writes and errors).
- rsp_addr  out  ADDR_WIDTH  address of the completed request.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts request.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  WORD_WIDTH  memory write data.
- mem_rvalid  in  1  memory completion, read data valid for reads.
- mem_rdata  in  WORD_WIDTH  memory read data.

Behaviour:
- Reset (async assert, sync deassert):
  - State = IDLE, last_grant = 1, so port 0 wins the first tie.
  - All outputs 0.
  - Counter 0.
  - Any in-flight transaction is dropped; no rsp_valid is issued for it.
- Reset mid-transaction: the memory side must also be reset; no response is generated after reset.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid, grant = the other port from last_grant if it is valid, else the valid one.
  - req_ready[grant] = 1 for exactly this cycle.
  - Latch write, addr, wdata and owner; set last_grant = grant.
  - Go to ISSUE.
- ISSUE:
  - mem_valid = 1; mem_write/addr/wdata come from the latched values and are stable until accepted.
  - Leave on the mem_valid & mem_ready cycle; go to WAIT with the counter cleared.
- WAIT:
  - Counter increments each cycle.
  - On mem_rvalid: latch mem_rdata (reads only), error = 0, go to RESP.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT without mem_rvalid: error = 1, data = 0, go to RESP.
  - mem_rvalid outside WAIT is ignored.
- RESP:
  - rsp_valid[owner] = 1 for one cycle, with rsp_addr = latched address, rsp_data and rsp_error.
  - Go to IDLE.
- Minimum turnaround: request accepted in cycle 0, mem_valid in cycle 1.
  - If mem_ready = 1 and mem_rvalid = 1 in cycle 2, rsp_valid is in cycle 3; the next grant can occur in cycle 4.
- Both ports valid continuously: grants strictly alternate 0,1,0,1.
- A single valid port is granted back-to-back regardless of last_grant.
- Requesters must hold req_valid, addr and wdata until req_ready.
- rsp_data, rsp_addr and rsp_error hold their last values outside RESP.
- rsp_valid is never asserted on both bits at once.

Test Plan:
- Reset with req_valid = 2'b11 held -> all outputs 0 during reset; after release, req_ready = 2'b01 first, then 2'b10 after port 0's response; rsp_valid alternates 01, 10.
- Port 1 read, addr 0x0ABCD; memory ready immediately, rvalid 1 cycle later with 0xDEADBEEF -> mem_addr = 0x0ABCD, mem_write = 0; rsp_valid = 2'b10, rsp_data = 0xDEADBEEF, rsp_addr = 0x0ABCD, rsp_error = 0, at the documented minimum latency (cycle 3).
- Port 0 write, addr 0x00010, data 0x12345678; mem_ready low for 5 cycles -> mem_valid/addr/wdata stable all 6 cycles; rsp_valid = 2'b01 with rsp_data = 0.
- TIMEOUT = 8, memory never returns rvalid -> exactly 8 WAIT cycles, then rsp_error = 1, rsp_data = 0, single rsp_valid; the next request is granted normally.
- Only port 0 valid for 4 back-to-back requests -> 4 grants to port 0; a stray mem_rvalid pulse in IDLE causes no response.
- Assert rst_n low during WAIT -> immediate return to IDLE, outputs 0, and no rsp_valid once rst_n rises.
